// File: rtl/nf10_ipif_arbiter.sv
// Round-robin arbiter sharing one Bus2IP/IP2Bus register-bank port between NUM_REQ requesters.
// One transaction in flight at a time, with ack timeout and error/data return to the grantee.
module nf10_ipif_arbiter #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_REQ            = 2,
    parameter int unsigned C_TIMEOUT          = 16
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                        req_rnw,
    input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH/8-1:0]   req_be,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             rsp_data,
    output logic                                      rsp_error,
    output logic                                      Bus2IP_CS,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]             Bus2IP_Addr,
    output logic                                      Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]           Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             IP2Bus_Data,
    input  logic                                      IP2Bus_RdAck,
    input  logic                                      IP2Bus_WrAck,
    input  logic                                      IP2Bus_Error,
    output logic [15:0]                               timeout_cnt
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned BW = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(C_TIMEOUT);

    localparam logic [GW-1:0] LastGrantInit = GW'(NUM_REQ - 1);
    localparam logic [TW-1:0] WaitLast      = TW'(C_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      gnt_q, gnt_d;
    logic [GW-1:0]      last_q, last_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               rnw_q, rnw_d;
    logic [DW-1:0]      data_q, data_d;
    logic [BW-1:0]      be_q, be_d;
    logic               cs_q, cs_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               rsp_error_q, rsp_error_d;
    logic [15:0]        tmo_cnt_q, tmo_cnt_d;

    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [DW-1:0] data_arr [NUM_REQ];
    logic [BW-1:0] be_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
        assign be_arr[i]   = req_be[i*BW +: BW];
    end

    // Search starts one past the last completed grant so every requester gets a turn.
    logic [GW-1:0] arb_idx;
    logic [GW-1:0] arb_pick;
    logic          arb_found;

    always_comb begin
        arb_idx   = '0;
        arb_pick  = '0;
        arb_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            arb_idx = GW'((32'(last_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx;
            end
        end
    end

    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               ack_match;

    assign pick_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_pick;
    assign gnt_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
    assign ack_match = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        data_d      = data_q;
        be_d        = be_q;
        cs_d        = cs_q;
        wait_d      = wait_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        tmo_cnt_d   = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    gnt_d       = arb_pick;
                    req_ready_d = pick_oh;
                    addr_d      = addr_arr[arb_pick];
                    rnw_d       = req_rnw[arb_pick];
                    data_d      = data_arr[arb_pick];
                    be_d        = be_arr[arb_pick];
                    wait_d      = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // First ISSUE cycle is the accept cycle; CS rises on the following one.
                if (!cs_q) begin
                    cs_d = 1'b1;
                end else if (ack_match) begin
                    rsp_data_d  = rnw_q ? IP2Bus_Data : '0;
                    rsp_error_d = IP2Bus_Error;
                    rsp_valid_d = gnt_oh;
                    cs_d        = 1'b0;
                    state_d     = StResp;
                end else if (wait_q == WaitLast) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = gnt_oh;
                    cs_d        = 1'b0;
                    if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    state_d     = StResp;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            StResp: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            last_q      <= LastGrantInit;
            addr_q      <= '0;
            rnw_q       <= 1'b1;
            data_q      <= '0;
            be_q        <= '0;
            cs_q        <= 1'b0;
            wait_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            data_q      <= data_d;
            be_q        <= be_d;
            cs_q        <= cs_d;
            wait_q      <= wait_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign Bus2IP_CS   = cs_q;
    assign Bus2IP_Addr = addr_q;
    assign Bus2IP_RNW  = rnw_q;
    assign Bus2IP_Data = data_q;
    assign Bus2IP_BE   = be_q;
    assign timeout_cnt = tmo_cnt_q;

    a_ready_onehot: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        $onehot0(req_ready_q));
    a_rsp_onehot: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        $onehot0(rsp_valid_q));
    a_no_cs_with_ready: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        !(cs_q && (|req_ready_q)));

endmodule

// File: tb/tb_nf10_ipif_arbiter.sv
// Scoreboard bench for nf10_ipif_arbiter: directed transactions push expected grants, CS
// lengths and responses; a negedge monitor pops and compares as the DUT presents them.
module tb_nf10_ipif_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_rnw;
    logic [63:0] req_data;
    logic [7:0]  req_be;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        Bus2IP_CS;
    logic [31:0] Bus2IP_Addr;
    logic        Bus2IP_RNW;
    logic [31:0] Bus2IP_Data;
    logic [3:0]  Bus2IP_BE;
    logic [31:0] IP2Bus_Data;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_Error;
    logic [15:0] timeout_cnt;

    always #5 clk = ~clk;

    nf10_ipif_arbiter #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .NUM_REQ           (2),
        .C_TIMEOUT         (16)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_rnw      (req_rnw),
        .req_data     (req_data),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .Bus2IP_CS    (Bus2IP_CS),
        .Bus2IP_Addr  (Bus2IP_Addr),
        .Bus2IP_RNW   (Bus2IP_RNW),
        .Bus2IP_Data  (Bus2IP_Data),
        .Bus2IP_BE    (Bus2IP_BE),
        .IP2Bus_Data  (IP2Bus_Data),
        .IP2Bus_RdAck (IP2Bus_RdAck),
        .IP2Bus_WrAck (IP2Bus_WrAck),
        .IP2Bus_Error (IP2Bus_Error),
        .timeout_cnt  (timeout_cnt)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   exp_len[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: DUT event did not arrive within the cycle budget", name);
    endtask

    // Register-bank responder: mode 0 never acks, 1 gives a matching ack on the
    // ack_delay-th CS cycle, 2 gives the wrong kind of ack on every CS cycle.
    int          ack_mode  = 0;
    int          ack_delay = 1;
    logic [31:0] ack_data  = '0;
    logic        ack_err   = 1'b0;
    int          age       = 0;

    initial begin
        IP2Bus_RdAck = 1'b0;
        IP2Bus_WrAck = 1'b0;
        IP2Bus_Data  = '0;
        IP2Bus_Error = 1'b0;
        forever begin
            @(negedge clk);
            age          = Bus2IP_CS ? age + 1 : 0;
            IP2Bus_RdAck = 1'b0;
            IP2Bus_WrAck = 1'b0;
            IP2Bus_Data  = '0;
            IP2Bus_Error = 1'b0;
            if (Bus2IP_CS) begin
                if (ack_mode == 1 && age == ack_delay) begin
                    IP2Bus_RdAck = Bus2IP_RNW;
                    IP2Bus_WrAck = !Bus2IP_RNW;
                    IP2Bus_Data  = ack_data;
                    IP2Bus_Error = ack_err;
                end else if (ack_mode == 2) begin
                    IP2Bus_RdAck = !Bus2IP_RNW;
                    IP2Bus_WrAck = Bus2IP_RNW;
                    IP2Bus_Data  = ack_data;
                end
            end
        end
    end

    // Monitor
    req_t cur;
    rsp_t mrsp;
    int   cs_run     = 0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_run     = 0;
            prev_ready = 1'b0;
        end else begin
            if (prev_ready) chk("cs_after_ready", 32'(Bus2IP_CS), 32'd1);
            if (|req_ready) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                chk("cs_low_at_ready", 32'(Bus2IP_CS), 32'd0);
                if (exp_req.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    cur = exp_req.pop_front();
                    chk("grant", 32'(req_ready), 32'd1 << cur.idx);
                end
            end
            prev_ready = |req_ready;
            if (Bus2IP_CS) begin
                cs_run++;
                chk("bus_addr", Bus2IP_Addr, cur.addr);
                chk("bus_rnw", 32'(Bus2IP_RNW), 32'(cur.rnw));
                chk("bus_data", Bus2IP_Data, cur.data);
                chk("bus_be", 32'(Bus2IP_BE), 32'(cur.be));
            end else if (cs_run > 0) begin
                chk("rsp_at_cs_fall", 32'(|rsp_valid), 32'd1);
                if (exp_len.size() == 0) chk("unexpected_cs_len", cs_run, 32'd0);
                else chk("cs_len", cs_run, exp_len.pop_front());
                cs_run = 0;
            end
            if (|rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mrsp = exp_rsp.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << mrsp.idx);
                    chk("rsp_data", rsp_data, mrsp.data);
                    chk("rsp_error", 32'(rsp_error), 32'(mrsp.err));
                end
            end
        end
    end

    // len < 0: transaction is expected to be cut short by reset (no CS length, no response).
    task automatic push_txn(input int idx, input logic [31:0] addr, input logic rnw,
                            input logic [31:0] data, input logic [3:0] be, input int len,
                            input logic [31:0] rdata, input logic err);
        req_t q;
        rsp_t r;
        q.idx = idx; q.addr = addr; q.rnw = rnw; q.data = data; q.be = be;
        exp_req.push_back(q);
        if (len >= 0) begin
            r.idx = idx; r.data = rdata; r.err = err;
            exp_len.push_back(len);
            exp_rsp.push_back(r);
        end
    endtask

    task automatic set_ack(input int mode, input int delay, input logic [31:0] d, input logic e);
        ack_mode = mode; ack_delay = delay; ack_data = d; ack_err = e;
    endtask

    task automatic do_req(input int idx, input logic [31:0] addr, input logic rnw,
                          input logic [31:0] data, input logic [3:0] be);
        bit got;
        got = 1'b0;
        req_addr[idx*32 +: 32] = addr;
        req_rnw[idx]           = rnw;
        req_data[idx*32 +: 32] = data;
        req_be[idx*4 +: 4]     = be;
        req_valid[idx]         = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = req_ready[idx];
        end
        if (!got) bound_fail("req_ready_wait");
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            got = |rsp_valid;
        end
        if (!got) bound_fail("rsp_valid_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = (exp_rsp.size() == 0);
        end
        if (!done) bound_fail("drain_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_cs"}, 32'(Bus2IP_CS), 32'd0);
        chk({tag, "_addr"}, Bus2IP_Addr, 32'd0);
        chk({tag, "_rnw"}, 32'(Bus2IP_RNW), 32'd1);
        chk({tag, "_wdata"}, Bus2IP_Data, 32'd0);
        chk({tag, "_be"}, 32'(Bus2IP_BE), 32'd0);
        chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_rnw   = '0;
        req_data  = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read, ack on the first CS cycle.
        set_ack(1, 1, 32'h0000_0203, 1'b0);
        push_txn(0, 32'h8, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0203, 1'b0);
        do_req(0, 32'h8, 1'b1, 32'h0, 4'hF);
        wait_rsp();

        // Single write from requester 1, WrAck on the 4th CS cycle; read data must not leak.
        set_ack(1, 4, 32'hDEAD_BEEF, 1'b0);
        push_txn(1, 32'h4, 1'b0, 32'hA5A5_A5A5, 4'hF, 4, 32'h0, 1'b0);
        do_req(1, 32'h4, 1'b0, 32'hA5A5_A5A5, 4'hF);
        wait_rsp();

        // Both requesters held: grants alternate 0,1,0,1.
        begin
            int seen;
            set_ack(1, 2, 32'h1111_2222, 1'b0);
            for (int k = 0; k < 2; k++) begin
                push_txn(0, 32'h10, 1'b1, 32'h100, 4'hF, 2, 32'h1111_2222, 1'b0);
                push_txn(1, 32'h14, 1'b1, 32'h101, 4'hF, 2, 32'h1111_2222, 1'b0);
            end
            req_addr  = {32'h14, 32'h10};
            req_data  = {32'h101, 32'h100};
            req_rnw   = 2'b11;
            req_be    = 8'hFF;
            req_valid = 2'b11;
            seen      = 0;
            for (int n = 0; n < 200 && seen < 4; n++) begin
                @(negedge clk);
                if (|req_ready) seen++;
            end
            if (seen < 4) bound_fail("round_robin_grants");
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            wait_drain();
        end

        // Read with no ack times out after 16 CS cycles.
        set_ack(0, 1, 32'h0, 1'b0);
        push_txn(0, 32'h30, 1'b1, 32'h0, 4'hF, 16, 32'h0, 1'b1);
        do_req(0, 32'h30, 1'b1, 32'h0, 4'hF);
        wait_rsp();
        chk("timeout_cnt_1", 32'(timeout_cnt), 32'd1);

        // Write answered only by RdAck: ignored, still times out.
        set_ack(2, 1, 32'h7777_7777, 1'b0);
        push_txn(1, 32'h34, 1'b0, 32'h5A5A_0000, 4'h3, 16, 32'h0, 1'b1);
        do_req(1, 32'h34, 1'b0, 32'h5A5A_0000, 4'h3);
        wait_rsp();
        chk("timeout_cnt_2", 32'(timeout_cnt), 32'd2);

        // Matching ack on the final (16th) CS cycle wins over the timeout.
        set_ack(1, 16, 32'h1234_5678, 1'b0);
        push_txn(0, 32'h38, 1'b1, 32'h0, 4'hF, 16, 32'h1234_5678, 1'b0);
        do_req(0, 32'h38, 1'b1, 32'h0, 4'hF);
        wait_rsp();
        chk("timeout_cnt_ack_wins", 32'(timeout_cnt), 32'd2);

        // Bank-reported error is passed through.
        set_ack(1, 3, 32'hCAFE_F00D, 1'b1);
        push_txn(0, 32'h3C, 1'b1, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 1'b1);
        do_req(0, 32'h3C, 1'b1, 32'h0, 4'hF);
        wait_rsp();

        // Reset while requester 1 is mid-ISSUE: no response, and requester 0 wins afterwards
        // even though requester 0 was the last one to complete.
        set_ack(0, 1, 32'h0, 1'b0);
        push_txn(1, 32'h40, 1'b1, 32'h0, 4'h3, -1, 32'h0, 1'b0);
        do_req(1, 32'h40, 1'b1, 32'h0, 4'h3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_ack(1, 1, 32'hABCD_0001, 1'b0);
        push_txn(0, 32'h50, 1'b1, 32'h0, 4'hF, 1, 32'hABCD_0001, 1'b0);
        push_txn(1, 32'h54, 1'b1, 32'h0, 4'hF, 1, 32'hABCD_0001, 1'b0);
        fork
            do_req(0, 32'h50, 1'b1, 32'h0, 4'hF);
            do_req(1, 32'h54, 1'b1, 32'h0, 4'hF);
        join
        wait_drain();

        chk("req_queue_empty", exp_req.size(), 32'd0);
        chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
